jtpopeye_dma: RTL and testbench

- Sprite DMA controller for the Popeye main board.
- Once per frame, at the start of vertical blank, it requests the Z80 bus and waits for bus acknowledge.
- It then streams a fixed window of main work RAM into the object (sprite) buffer and releases the bus.
- It sits beside the main CPU and drives the CPU BUSRQ_n input, the DMCS work-RAM select and the sprite-buffer write port.

---
 rtl/jtpopeye_dma.sv | 130 +++++++++++++
 tb/tb_jtpopeye_dma.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_dma.sv
// Sprite DMA for the Popeye main board: once per frame, at blank start, it
// takes the Z80 bus and copies a fixed work-RAM window into the sprite buffer.
module jtpopeye_dma #(
    parameter int              AW       = 11,
    parameter logic [AW-1:0]   SRC_BASE = 11'h400,
    parameter logic [9:0]      LEN      = 10'd384,
    parameter logic [7:0]      TIMEOUT  = 8'd255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          LVBL,
    input  logic          busak_n,
    input  logic [7:0]    ram_dout,
    output logic          bus_req,
    output logic          DMCS,
    output logic [AW-1:0] dma_addr,
    output logic [9:0]    obj_addr,
    output logic [7:0]    obj_din,
    output logic          obj_we,
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [9:0] LAST = LEN - 10'd1;

    state_t        state_q;
    logic          lvbl_q;
    logic [7:0]    wait_q;
    logic [9:0]    cnt_q;
    logic          bus_req_q;
    logic          dmcs_q;
    logic          busy_q;
    logic          terr_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [9:0]    obj_addr_q;

    logic          trig;
    logic [7:0]    wait_inc;

    // Blank start is a falling edge of the registered LVBL, seen on a cen
    assign trig     = lvbl_q & ~LVBL;
    assign wait_inc = wait_q + 8'd1;

    // Single FSM: bus request handshake, pipelined copy and bus release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lvbl_q     <= 1'b0;
            wait_q     <= 8'd0;
            cnt_q      <= 10'd0;
            bus_req_q  <= 1'b0;
            dmcs_q     <= 1'b0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= SRC_BASE;
            obj_addr_q <= 10'd0;
        end else if (cen) begin
            lvbl_q <= LVBL;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q   <= REQ;
                        bus_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        wait_q    <= 8'd0;
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        state_q <= XFER;
                        dmcs_q  <= 1'b1;
                        addr_q  <= SRC_BASE;
                        cnt_q   <= 10'd0;
                    end else if (LVBL || wait_inc == TIMEOUT) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        busy_q    <= 1'b0;
                        terr_q    <= 1'b1;
                    end else begin
                        wait_q <= wait_inc;
                    end
                end
                XFER: begin
                    // Write side trails the address by one cen (RAM latency)
                    obj_addr_q <= cnt_q;
                    if (cnt_q < LAST) begin
                        addr_q <= addr_q + {{(AW-1){1'b0}}, 1'b1};
                    end
                    if (cnt_q == LEN) begin
                        state_q   <= REL;
                        we_q      <= 1'b0;
                        dmcs_q    <= 1'b0;
                        bus_req_q <= 1'b0;
                    end else begin
                        we_q  <= 1'b1;
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                REL: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_req     = bus_req_q;
    assign DMCS        = dmcs_q;
    assign dma_addr    = addr_q;
    assign obj_addr    = obj_addr_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    // Strobe qualified by cen so a slow sink never sees a multi-edge write
    assign obj_we      = we_q & cen;
    assign obj_din     = we_q ? ram_dout : 8'h00;

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Bench for jtpopeye_dma: a default instance and a small wrapping instance,
// each with a registered RAM model and a write scoreboard.
module tb_jtpopeye_dma;

    localparam int LEN   = 384;
    localparam int LENW  = 32;
    localparam int SRC   = 'h400;
    localparam int SRCW  = 'h7F0;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        cen = 1'b0;
    logic        rst_n;
    logic        LVBL, busak_n, LVBL_w, busak_w;
    logic [7:0]  ram_dout = 8'h00;
    logic [7:0]  ram_dout_w = 8'h00;
    logic        bus_req, DMCS, obj_we, busy, timeout_err;
    logic [10:0] dma_addr;
    logic [9:0]  obj_addr;
    logic [7:0]  obj_din;
    logic        bus_req_w, DMCS_w, obj_we_w, busy_w, timeout_err_w;
    logic [10:0] dma_addr_w;
    logic [9:0]  obj_addr_w;
    logic [7:0]  obj_din_w;

    logic [7:0]  mem  [2048];
    logic [7:0]  memw [2048];

    wr_t         expQ[$];
    wr_t         expQw[$];
    logic [10:0] addrQw[$];

    int checks = 0;
    int fails  = 0;
    int weCount = 0;
    int weCountW = 0;
    int sampleIdx = 0;
    int lastWeIdx = 0;
    int fallIdx = 0;
    logic busReqPrev = 1'b0;

    jtpopeye_dma dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .busak_n(busak_n),
        .ram_dout(ram_dout), .bus_req(bus_req), .DMCS(DMCS), .dma_addr(dma_addr),
        .obj_addr(obj_addr), .obj_din(obj_din), .obj_we(obj_we), .busy(busy),
        .timeout_err(timeout_err)
    );

    jtpopeye_dma #(.AW(11), .SRC_BASE(11'h7F0), .LEN(10'd32), .TIMEOUT(8'd255)) dutw (
        .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL_w), .busak_n(busak_w),
        .ram_dout(ram_dout_w), .bus_req(bus_req_w), .DMCS(DMCS_w), .dma_addr(dma_addr_w),
        .obj_addr(obj_addr_w), .obj_din(obj_din_w), .obj_we(obj_we_w), .busy(busy_w),
        .timeout_err(timeout_err_w)
    );

    // Clock and a half-rate clock enable
    always #5 clk = ~clk;

    always @(posedge clk) cen <= ~cen;

    // Registered work-RAM models, one cen of read latency
    always @(posedge clk) begin
        if (cen) begin
            ram_dout   <= mem[dma_addr];
            ram_dout_w <= memw[dma_addr_w];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cenStep();
        do @(negedge clk); while (!cen);
    endtask

    // Queue the writes a full frame must produce from the current RAM image
    task automatic applyStimulus(input bit wrapSel);
        wr_t w;
        if (!wrapSel) begin
            for (int i = 0; i < LEN; i++) begin
                w.addr = 10'(i);
                w.data = mem[11'((SRC + i) % 2048)];
                expQ.push_back(w);
            end
        end else begin
            for (int i = 0; i < LENW; i++) begin
                w.addr = 10'(i);
                w.data = memw[11'((SRCW + i) % 2048)];
                expQw.push_back(w);
            end
            for (int k = 0; k <= LENW; k++) begin
                addrQw.push_back(11'((SRCW + ((k < LENW) ? k : LENW - 1)) % 2048));
            end
        end
    endtask

    task automatic waitDone(input bit wrapSel, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cenStep();
            if (!(wrapSel ? busy_w : busy)) done = 1'b1;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    // Scoreboard: one sample per cen period, just before the active edge
    always @(negedge clk) begin
        if (cen && rst_n) begin
            sampleIdx++;
            if (busReqPrev && !bus_req) fallIdx = sampleIdx;
            busReqPrev = bus_req;
            if (obj_we) begin
                wr_t e;
                weCount++;
                lastWeIdx = sampleIdx;
                checkOutput("we_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("obj_addr", 32'(obj_addr), 32'(e.addr));
                    checkOutput("obj_din", 32'(obj_din), 32'(e.data));
                end
            end
            if (DMCS_w) begin
                logic [10:0] a;
                checkOutput("w_addr_expected", 32'(addrQw.size() > 0), 32'd1);
                if (addrQw.size() > 0) begin
                    a = addrQw.pop_front();
                    checkOutput("w_dma_addr", 32'(dma_addr_w), 32'(a));
                end
            end
            if (obj_we_w) begin
                wr_t e;
                weCountW++;
                checkOutput("w_we_expected", 32'(expQw.size() > 0), 32'd1);
                if (expQw.size() > 0) begin
                    e = expQw.pop_front();
                    checkOutput("w_obj_addr", 32'(obj_addr_w), 32'(e.addr));
                    checkOutput("w_obj_din", 32'(obj_din_w), 32'(e.data));
                end
            end
        end
    end

    // Directed sequence of frames
    initial begin
        int base;
        int n;
        rst_n = 1'b0; LVBL = 1'b1; busak_n = 1'b1; LVBL_w = 1'b1; busak_w = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            mem[i]  = 8'(i * 7 + 1);
            memw[i] = 8'(i + 8'h33);
        end
        for (int i = 0; i < LEN; i++) mem[SRC + i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < LENW; i++) memw[(SRCW + i) % 2048] = 8'(8'hA0 + i);

        repeat (3) @(negedge clk);
        checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("rst_DMCS", 32'(DMCS), 32'd0);
        checkOutput("rst_obj_we", 32'(obj_we), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_dma_addr", 32'(dma_addr), 32'h400);
        checkOutput("rst_obj_addr", 32'(obj_addr), 32'd0);
        checkOutput("rst_obj_din", 32'(obj_din), 32'd0);
        rst_n = 1'b1;
        repeat (4) cenStep();

        $display("[TB] normal frame");
        applyStimulus(1'b0);
        base = weCount;
        LVBL = 1'b0;
        repeat (2) cenStep();
        busak_n = 1'b0;
        waitDone(1'b0, "normal_done");
        checkOutput("normal_count", 32'(weCount - base), 32'(LEN));
        checkOutput("normal_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("normal_busreq_drop", 32'(fallIdx), 32'(lastWeIdx + 1));
        checkOutput("normal_bus_req_low", 32'(bus_req), 32'd0);
        checkOutput("normal_DMCS_low", 32'(DMCS), 32'd0);
        checkOutput("normal_timeout_err", 32'(timeout_err), 32'd0);
        busak_n = 1'b1; LVBL = 1'b1;
        repeat (4) cenStep();

        $display("[TB] address wrap instance");
        applyStimulus(1'b1);
        LVBL_w = 1'b0;
        cenStep();
        busak_w = 1'b0;
        waitDone(1'b1, "wrap_done");
        checkOutput("wrap_count", 32'(weCountW), 32'(LENW));
        checkOutput("wrap_addr_queue_empty", 32'(addrQw.size()), 32'd0);
        checkOutput("wrap_wr_queue_empty", 32'(expQw.size()), 32'd0);
        busak_w = 1'b1; LVBL_w = 1'b1;
        repeat (4) cenStep();

        $display("[TB] late grant");
        for (int i = 0; i < LEN; i++) mem[SRC + i] = 8'(i * 3 + 7);
        applyStimulus(1'b0);
        base = weCount;
        LVBL = 1'b0;
        repeat (100) cenStep();
        checkOutput("late_bus_req_held", 32'(bus_req), 32'd1);
        checkOutput("late_DMCS_low", 32'(DMCS), 32'd0);
        busak_n = 1'b0;
        cenStep();
        checkOutput("late_DMCS_next_cen", 32'(DMCS), 32'd1);
        waitDone(1'b0, "late_done");
        checkOutput("late_count", 32'(weCount - base), 32'(LEN));
        checkOutput("late_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("late_timeout_err", 32'(timeout_err), 32'd0);
        busak_n = 1'b1; LVBL = 1'b1;
        repeat (4) cenStep();

        $display("[TB] no grant, timeout");
        base = weCount;
        LVBL = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            cenStep();
            if (bus_req) n++;
            else if (n > 0) break;
        end
        checkOutput("timeout_req_cens", 32'(n), 32'd255);
        checkOutput("timeout_err_set", 32'(timeout_err), 32'd1);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        checkOutput("timeout_no_writes", 32'(weCount - base), 32'd0);
        LVBL = 1'b1;
        repeat (4) cenStep();

        $display("[TB] no grant, blank ends");
        LVBL = 1'b0;
        repeat (20) cenStep();
        checkOutput("lvbl_abort_req_held", 32'(bus_req), 32'd1);
        LVBL = 1'b1;
        cenStep();
        checkOutput("lvbl_abort_bus_req", 32'(bus_req), 32'd0);
        checkOutput("lvbl_abort_busy", 32'(busy), 32'd0);
        checkOutput("lvbl_abort_sticky", 32'(timeout_err), 32'd1);
        checkOutput("lvbl_abort_no_writes", 32'(weCount - base), 32'd0);
        repeat (4) cenStep();

        $display("[TB] retrigger and blank end during copy");
        applyStimulus(1'b0);
        base = weCount;
        LVBL = 1'b0;
        cenStep();
        busak_n = 1'b0;
        repeat (50) cenStep();
        LVBL = 1'b1;
        repeat (10) cenStep();
        LVBL = 1'b0;
        repeat (10) cenStep();
        LVBL = 1'b1;
        waitDone(1'b0, "retrig_done");
        checkOutput("retrig_count", 32'(weCount - base), 32'(LEN));
        checkOutput("retrig_queue_empty", 32'(expQ.size()), 32'd0);
        repeat (20) cenStep();
        checkOutput("retrig_no_restart", 32'(busy), 32'd0);
        checkOutput("retrig_no_extra", 32'(weCount - base), 32'(LEN));
        busak_n = 1'b1;
        repeat (4) cenStep();

        $display("[TB] reset mid copy");
        applyStimulus(1'b0);
        base = weCount;
        LVBL = 1'b0;
        cenStep();
        busak_n = 1'b0;
        for (int i = 0; i < 500 && (weCount - base) < 100; i++) cenStep();
        checkOutput("midrst_reached_100", 32'((weCount - base) >= 100), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_bus_req", 32'(bus_req), 32'd0);
        checkOutput("midrst_DMCS", 32'(DMCS), 32'd0);
        checkOutput("midrst_obj_we", 32'(obj_we), 32'd0);
        checkOutput("midrst_timeout_clr", 32'(timeout_err), 32'd0);
        expQ.delete();
        LVBL = 1'b1; busak_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cenStep();
        applyStimulus(1'b0);
        base = weCount;
        LVBL = 1'b0;
        repeat (2) cenStep();
        busak_n = 1'b0;
        waitDone(1'b0, "after_rst_done");
        checkOutput("after_rst_count", 32'(weCount - base), 32'(LEN));
        checkOutput("after_rst_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("after_rst_timeout_err", 32'(timeout_err), 32'd0);
        busak_n = 1'b1; LVBL = 1'b1;
        repeat (4) cenStep();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
